// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, LSB first, start/busy/done handshake.
//            Define SERIAL_SUB_EN to add the op port and subtract mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_SUB_EN
  input  logic             op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int             CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_shift;
  logic [CW-1:0]      r_cnt;
  logic               r_carry;
`ifdef SERIAL_SUB_EN
  logic               r_op;
`endif

  logic               w_x;
  logic               w_bit;
  logic               w_carry_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;

  assign w_x   = r_a[0] ^ r_b[0];
  assign w_bit = w_x ^ r_carry;

`ifdef SERIAL_SUB_EN
  // r_carry holds the borrow when r_op is set
  assign w_carry_nxt = r_op ? ((~r_a[0] & r_b[0]) | (~w_x & r_carry))
                            : ((r_a[0] & r_b[0]) | (r_carry & w_x));
`else
  assign w_carry_nxt = (r_a[0] & r_b[0]) | (r_carry & w_x);
`endif

  // new bit enters at the MSB; after WIDTH shifts the result is LSB-aligned
  assign w_shift_nxt = {w_bit, r_shift};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
`ifdef SERIAL_SUB_EN
      r_op    <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      c_out   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_nxt;
          r_shift <= w_shift_nxt[WIDTH-1:1];
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            sum     <= w_shift_nxt;
            c_out   <= w_carry_nxt;
          end
        end
        default: begin
          // IDLE and DONE both accept a new start, so back-to-back ops have no gap
          done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
`ifdef SERIAL_SUB_EN
            r_op    <= op;
`endif
            r_state <= S_RUN;
            busy    <= 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Brief    : Scoreboard bench for serial_adder (WIDTH=8), add and optional sub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int total = 0;
  int bad   = 0;
  logic [8:0] q[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef SERIAL_SUB_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // {carry/borrow, result}
  function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic o);
    if (o) return {1'b0, x} - {1'b0, y} - {8'd0, ci};
    return {1'b0, x} + {1'b0, y} + {8'd0, ci};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = q.pop_front();
        check("sum_cout", {23'd0, c_out, sum}, {23'd0, e});
      end
    end
  end

  task automatic wait_done(output int n, output int nb);
    n  = 0;
    nb = 0;
    while (!done && n < 40) begin
      if (busy) nb++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb2,
                        input logic tci, input logic top);
    logic [8:0] e;
    int n, nb;
    e = model(ta, tb2, tci, top);
    a = ta; b = tb2; c_in = tci; op = top; start = 1'b1;
    q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, nb);
    check("latency", n, 8);
    check("busy_cycles", nb, 8);
    @(posedge clk); #1;
    check("done_width", {31'd0, done}, 32'd0);
    check("sum_hold", {23'd0, c_out, sum}, {23'd0, e});
  endtask

  initial begin
    int n, nb, ndone;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sum", {24'd0, sum}, 0);
    check("rst_cout", {31'd0, c_out}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h35, 8'h4A, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b1, 1'b0);

    // mid-clock async reset clears outputs at once
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 0);
    check("async_done", {31'd0, done}, 0);
    check("async_sum", {24'd0, sum}, 0);
    check("async_cout", {31'd0, c_out}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // start while busy is ignored; start held in DONE is accepted
    a = 8'h35; b = 8'h4A; c_in = 1'b0; op = 1'b0; start = 1'b1;
    q.push_back(model(8'h35, 8'h4A, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (n == 3) begin a = 8'h00; b = 8'h00; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("ign_latency", n, 8);
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    q.push_back(model(8'h01, 8'h01, 1'b0, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 1);
    check("b2b_done_drop", {31'd0, done}, 0);
    wait_done(n, nb);
    check("b2b_latency", n, 8);
    @(posedge clk); #1;
    check("b2b_hold", {24'd0, sum}, 32'h02);

    // reset during RUN aborts without a done pulse
    a = 8'h55; b = 8'h11; c_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_sum", {24'd0, sum}, 0);
    check("abort_cout", {31'd0, c_out}, 0);
    @(negedge clk) rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", {31'd0, busy}, 0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
    run_op(8'h10, 8'h20, 1'b0, 1'b1);
    run_op(8'h03, 8'h01, 1'b1, 1'b1);
    run_op(8'h03, 8'h01, 1'b1, 1'b0);
`endif

    repeat (6) begin
      logic [7:0] ra, rb;
      logic rc, ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom_range(1));
`ifdef SERIAL_SUB_EN
      ro = 1'($urandom_range(1));
`else
      ro = 1'b0;
`endif
      run_op(ra, rb, rc, ro);
    end

    repeat (2) @(posedge clk);
    check("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
